// File: rtl/stopwatch_lap_timer_if.sv
// stopwatch_lap_timer_if: command, preset, time and lap-FIFO signals of the stopwatch/lap timer.
// Latency: none, wiring only.
// Backpressure: none; lap_rd pops are ignored while lap_valid is low.
interface stopwatch_lap_timer_if #(
    parameter int LAP_DEPTH = 4
);
    localparam int CW = $clog2(LAP_DEPTH) + 1;

    logic          btn_runstop;
    logic          btn_clear;
    logic          btn_lap;
    logic [7:0]    uart_rx;
    logic          uart_rx_done;
    logic          mode;
    logic          load;
    logic [23:0]   preset;
    logic          lap_rd;
    logic [6:0]    msec;
    logic [5:0]    sec;
    logic [5:0]    min;
    logic [4:0]    hour;
    logic          running;
    logic          expired;
    logic [23:0]   lap_data;
    logic          lap_valid;
    logic [CW-1:0] lap_count;
    logic          lap_ovf;

    // Command/preset source side (button and UART front-end, host).
    modport master (
        output btn_runstop, btn_clear, btn_lap, uart_rx, uart_rx_done,
               mode, load, preset, lap_rd,
        input  msec, sec, min, hour, running, expired,
               lap_data, lap_valid, lap_count, lap_ovf
    );

    // Timer side.
    modport slave (
        input  btn_runstop, btn_clear, btn_lap, uart_rx, uart_rx_done,
               mode, load, preset, lap_rd,
        output msec, sec, min, hour, running, expired,
               lap_data, lap_valid, lap_count, lap_ovf
    );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: hh:mm:ss.cc up/down counter with preset load, expiry pulse and lap FIFO.
// Latency: commands act on the next edge; fields update on the edge after the prescaler terminal count.
// Backpressure: none; laps arriving on a full FIFO are dropped and flagged sticky in lap_ovf.
// Optional: define STOPWATCH_UART_CMD_EN to accept R/C/L (either case) commands from the UART RX bytes.
module stopwatch_lap_timer #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int HOUR_MAX  = 24,
    parameter int LAP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_lap_timer_if.slave bus
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [4:0] HOUR_TOP = 5'(HOUR_MAX - 1);

    typedef enum logic {ST_STOP, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    msec_q, msec_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          mode_q;
    logic          expired_q;
    logic [23:0]   lap_mem_q [LAP_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;

    logic uart_rs, uart_clr, uart_lap;
    logic ev_rs, ev_clr, ev_lap;
    logic in_stop, all_zero, tick, down_done;
    logic push_req, push, pop, full, drop;
    logic [4:0] p_hour;
    logic [5:0] p_min, p_sec;
    logic [6:0] p_msec;

`ifdef STOPWATCH_UART_CMD_EN
    // ASCII 'R'/'r', 'C'/'c', 'L'/'l'.
    assign uart_rs  = bus.uart_rx_done && (bus.uart_rx == 8'h52 || bus.uart_rx == 8'h72);
    assign uart_clr = bus.uart_rx_done && (bus.uart_rx == 8'h43 || bus.uart_rx == 8'h63);
    assign uart_lap = bus.uart_rx_done && (bus.uart_rx == 8'h4C || bus.uart_rx == 8'h6C);
`else
    // UART inputs stay on the port list but feed nothing.
    logic uart_unused;
    assign uart_unused = ^{bus.uart_rx, bus.uart_rx_done};
    assign uart_rs  = 1'b0;
    assign uart_clr = 1'b0;
    assign uart_lap = 1'b0;
`endif

    // A button and a UART byte for the same command in one cycle merge into one event.
    assign ev_rs  = bus.btn_runstop | uart_rs;
    assign ev_clr = bus.btn_clear   | uart_clr;
    assign ev_lap = bus.btn_lap     | uart_lap;

    assign in_stop   = (state_q == ST_STOP);
    assign all_zero  = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0) && (msec_q == 7'd0);
    assign tick      = !in_stop && (presc_q == PW'(DIV - 1));
    assign down_done = tick && mode_q && (hour_q == 5'd0) && (min_q == 6'd0)
                       && (sec_q == 6'd0) && (msec_q == 7'd1);

    assign p_hour = bus.preset[23:19];
    assign p_min  = bus.preset[18:13];
    assign p_sec  = bus.preset[12:7];
    assign p_msec = bus.preset[6:0];

    // Run/stop decision; a down-count cannot start from zero, clear beats runstop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (!ev_clr && ev_rs && !(mode_q && all_zero)) state_d = ST_RUN;
            ST_RUN:  if (ev_rs || down_done) state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    // Time fields and prescaler: clear/load while stopped, count on each tick while running.
    always_comb begin
        presc_d = presc_q;
        msec_d  = msec_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        if (in_stop) begin
            if (ev_clr) begin
                presc_d = '0;
                msec_d  = '0;
                sec_d   = '0;
                min_d   = '0;
                hour_d  = '0;
            end else if (bus.load) begin
                presc_d = '0;
                msec_d  = (p_msec > 7'd99)  ? 7'd99  : p_msec;
                sec_d   = (p_sec  > 6'd59)  ? 6'd59  : p_sec;
                min_d   = (p_min  > 6'd59)  ? 6'd59  : p_min;
                hour_d  = (p_hour > HOUR_TOP) ? HOUR_TOP : p_hour;
            end
        end else if (tick) begin
            presc_d = '0;
            if (!mode_q) begin
                if (msec_q == 7'd99) begin
                    msec_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d  = '0;
                            hour_d = (hour_q == HOUR_TOP) ? 5'd0 : hour_q + 5'd1;
                        end else min_d = min_q + 6'd1;
                    end else sec_d = sec_q + 6'd1;
                end else msec_d = msec_q + 7'd1;
            end else if (!all_zero) begin
                if (msec_q == 7'd0) begin
                    msec_d = 7'd99;
                    if (sec_q == 6'd0) begin
                        sec_d = 6'd59;
                        if (min_q == 6'd0) begin
                            min_d  = 6'd59;
                            hour_d = hour_q - 5'd1;
                        end else min_d = min_q - 6'd1;
                    end else sec_d = sec_q - 6'd1;
                end else msec_d = msec_q - 7'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Timer state registers; mode is tracked while stopped and frozen while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_STOP;
            presc_q   <= '0;
            msec_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            msec_q    <= msec_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            expired_q <= down_done;
            if (in_stop) mode_q <= bus.mode;
        end
    end

    // Lap FIFO control; a pop in the same cycle frees room for a push into a full FIFO.
    assign push_req = ev_lap && !in_stop;
    assign pop      = bus.lap_rd && (cnt_q != '0);
    assign full     = (cnt_q == CW'(LAP_DEPTH));
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Lap FIFO storage and pointers; clear while stopped empties it and drops the overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= '0;
        end else if (in_stop && ev_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                lap_mem_q[wr_ptr_q] <= {hour_q, min_q, sec_q, msec_q};
                wr_ptr_q            <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign bus.msec      = msec_q;
    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = hour_q;
    assign bus.running   = (state_q == ST_RUN);
    assign bus.expired   = expired_q;
    assign bus.lap_data  = lap_mem_q[rd_ptr_q];
    assign bus.lap_valid = (cnt_q != '0);
    assign bus.lap_count = cnt_q;
    assign bus.lap_ovf   = ovf_q;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// tb_stopwatch_lap_timer: self-checking bench for stopwatch_lap_timer (10 clocks per tick, HOUR_MAX=2, 4 laps).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: not applicable; lap results flow through an expected-value queue.
module tb_stopwatch_lap_timer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_lap_timer_if #(.LAP_DEPTH(4)) bus ();

    stopwatch_lap_timer #(
        .CLK_FREQ(1000), .TICK_HZ(100), .HOUR_MAX(2), .LAP_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [23:0] preset;
        int          h, m, s, c;
    } ld_vec_t;

    typedef struct {
        logic [7:0] rx;
        logic       done;
        logic       btn;
        logic       exp_run;
    } cmd_vec_t;

    ld_vec_t  ld_tbl [5];
    cmd_vec_t cmd_tbl [5];
    int       exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // 0 runstop, 1 clear, 2 lap, 3 lap_rd, 4 load
    task automatic press(input int which);
        case (which)
            0: bus.btn_runstop = 1'b1;
            1: bus.btn_clear   = 1'b1;
            2: bus.btn_lap     = 1'b1;
            3: bus.lap_rd      = 1'b1;
            default: bus.load  = 1'b1;
        endcase
        step();
        bus.btn_runstop = 1'b0;
        bus.btn_clear   = 1'b0;
        bus.btn_lap     = 1'b0;
        bus.lap_rd      = 1'b0;
        bus.load        = 1'b0;
    endtask

    task automatic load_preset(input logic [23:0] p);
        bus.preset = p;
        press(4);
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s, input int c);
        chk({name, ".hour"}, int'(bus.hour), h);
        chk({name, ".min"},  int'(bus.min),  m);
        chk({name, ".sec"},  int'(bus.sec),  s);
        chk({name, ".msec"}, int'(bus.msec), c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit exp_run;

        ld_tbl[0] = '{{5'd0,  6'd0,  6'd0,  7'd3},   0, 0,  0,  3};
        ld_tbl[1] = '{{5'd1,  6'd59, 6'd59, 7'd99},  1, 59, 59, 99};
        ld_tbl[2] = '{{5'd31, 6'd63, 6'd60, 7'd127}, 1, 59, 59, 99};
        ld_tbl[3] = '{{5'd0,  6'd30, 6'd61, 7'd100}, 0, 30, 59, 99};
        ld_tbl[4] = '{{5'd2,  6'd5,  6'd6,  7'd7},   1, 5,  6,  7};
`ifdef STOPWATCH_UART_CMD_EN
        cmd_tbl[0] = '{8'h72, 1'b1, 1'b0, 1'b1};
        cmd_tbl[1] = '{8'h78, 1'b1, 1'b0, 1'b1};
        cmd_tbl[2] = '{8'h52, 1'b1, 1'b1, 1'b0};
        cmd_tbl[3] = '{8'h72, 1'b0, 1'b0, 1'b0};
        cmd_tbl[4] = '{8'h72, 1'b1, 1'b1, 1'b1};
`else
        cmd_tbl[0] = '{8'h72, 1'b1, 1'b0, 1'b0};
        cmd_tbl[1] = '{8'h78, 1'b1, 1'b0, 1'b0};
        cmd_tbl[2] = '{8'h52, 1'b1, 1'b1, 1'b1};
        cmd_tbl[3] = '{8'h72, 1'b0, 1'b0, 1'b1};
        cmd_tbl[4] = '{8'h72, 1'b1, 1'b1, 1'b0};
`endif

        bus.btn_runstop = 1'b0; bus.btn_clear = 1'b0; bus.btn_lap = 1'b0;
        bus.uart_rx = 8'h00; bus.uart_rx_done = 1'b0; bus.mode = 1'b0;
        bus.load = 1'b0; bus.preset = '0; bus.lap_rd = 1'b0;

        // Reset state.
        repeat (3) step();
        chk_time("reset", 0, 0, 0, 0);
        chk("reset.running",   int'(bus.running),   0);
        chk("reset.expired",   int'(bus.expired),   0);
        chk("reset.lap_valid", int'(bus.lap_valid), 0);
        chk("reset.lap_count", int'(bus.lap_count), 0);
        chk("reset.lap_ovf",   int'(bus.lap_ovf),   0);
        rst = 1'b1;
        step();

        // 1000 clocks of running = 100 ticks = 1.00 s; then stop and hold.
        press(0);
        repeat (1000) step();
        chk_time("run1s", 0, 0, 1, 0);
        chk("run1s.running", int'(bus.running), 1);
        press(0);
        repeat (50) step();
        chk_time("hold", 0, 0, 1, 0);
        chk("hold.running", int'(bus.running), 0);

        // Preset load with saturation.
        for (int i = 0; i < 5; i++) begin
            load_preset(ld_tbl[i].preset);
            chk_time($sformatf("load%0d", i), ld_tbl[i].h, ld_tbl[i].m, ld_tbl[i].s, ld_tbl[i].c);
        end

        // Full up-count rollover at HOUR_MAX-1 keeps running; load while running is ignored.
        load_preset({5'd1, 6'd59, 6'd59, 7'd99});
        press(0);
        repeat (9) step();
        chk_time("pre_roll", 1, 59, 59, 99);
        step();
        chk_time("roll", 0, 0, 0, 0);
        chk("roll.running", int'(bus.running), 1);
        load_preset({5'd0, 6'd0, 6'd0, 7'd3});
        chk("load_in_run.msec", int'(bus.msec), 0);
        press(0);

        // Countdown from 0.03 to zero: stop plus single-cycle expiry pulse.
        bus.mode = 1'b1;
        step();
        load_preset({5'd0, 6'd0, 6'd0, 7'd3});
        press(0);
        repeat (29) step();
        chk("cd_pre.msec",    int'(bus.msec),    1);
        chk("cd_pre.running", int'(bus.running), 1);
        chk("cd_pre.expired", int'(bus.expired), 0);
        step();
        chk_time("cd_zero", 0, 0, 0, 0);
        chk("cd_zero.running", int'(bus.running), 0);
        chk("cd_zero.expired", int'(bus.expired), 1);
        step();
        chk("cd_after.expired", int'(bus.expired), 0);
        press(0);
        chk("cd_restart.running", int'(bus.running), 0);

        // Countdown borrow across every field.
        load_preset({5'd1, 6'd0, 6'd0, 7'd0});
        press(0);
        repeat (10) step();
        chk_time("borrow", 0, 59, 59, 99);
        press(0);
        bus.mode = 1'b0;
        step();

        // Laps: ignored in STOP, then five captures into a 4-deep FIFO.
        press(1);
        press(2);
        chk("lap_in_stop.count", int'(bus.lap_count), 0);
        press(0);
        repeat (14) step();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(i + 1);
            press(2);
            repeat (9) step();
        end
        chk("laps.count", int'(bus.lap_count), 4);
        chk("laps.ovf",   int'(bus.lap_ovf),   1);
        chk("laps.valid", int'(bus.lap_valid), 1);
        press(0);
        while (exp_q.size() > 0) begin
            chk("lap_pop.data", int'(bus.lap_data), exp_q.pop_front());
            press(3);
        end
        chk("lap_drained.valid", int'(bus.lap_valid), 0);
        press(3);
        chk("lap_rd_empty.count", int'(bus.lap_count), 0);
        chk("lap_ovf_sticky", int'(bus.lap_ovf), 1);
        press(1);
        chk("lap_clear.ovf", int'(bus.lap_ovf), 0);

        // Push and pop together on a full FIFO: both happen, no overflow.
        press(0);
        repeat (4) press(2);
        bus.btn_lap = 1'b1;
        press(3);
        chk("lap_pushpop.count", int'(bus.lap_count), 4);
        chk("lap_pushpop.ovf",   int'(bus.lap_ovf),   0);
        press(0);
        press(1);

        // Command decode: buttons and UART bytes.
        exp_run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.uart_rx      = cmd_tbl[i].rx;
            bus.uart_rx_done = cmd_tbl[i].done;
            bus.btn_runstop  = cmd_tbl[i].btn;
            step();
            bus.uart_rx_done = 1'b0;
            bus.btn_runstop  = 1'b0;
            exp_run = cmd_tbl[i].exp_run;
            chk($sformatf("cmd%0d.running", i), int'(bus.running), int'(exp_run));
        end
        if (exp_run) press(0);

        // Clear and runstop together while stopped: clear wins.
        load_preset({5'd0, 6'd0, 6'd5, 7'd0});
        chk("clr_rs_pre.sec", int'(bus.sec), 5);
        bus.btn_clear = 1'b1;
        press(0);
        chk_time("clr_rs", 0, 0, 0, 0);
        chk("clr_rs.running", int'(bus.running), 0);

        // Asynchronous reset in the middle of a run with a lap held.
        press(0);
        repeat (25) step();
        press(2);
        #2;
        rst = 1'b0;
        #1;
        chk_time("arst", 0, 0, 0, 0);
        chk("arst.running",   int'(bus.running),   0);
        chk("arst.lap_count", int'(bus.lap_count), 0);
        chk("arst.lap_valid", int'(bus.lap_valid), 0);
        step();
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_lap_timer.md
Name: stopwatch_lap_timer

Overview:
- Parametrised successor to the stopwatch top: counts hh:mm:ss.cc up (stopwatch) or down (countdown timer).
- Runs from one system clock with an internal prescaler.
- Adds lap capture into a LAP_DEPTH-entry FIFO, countdown preset load with expiry flag, and unified button/UART command decode.
- Sits between the debounced-button / UART RX blocks and the FND/display formatter.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count resolution in Hz; the lowest field counts 0..99. CLK_FREQ/TICK_HZ must be an integer ≥2.
- HOUR_MAX, 24, hour modulus; hour counts 0..HOUR_MAX-1; HOUR_MAX ≤ 32.
- LAP_DEPTH, 4, lap FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- btn_runstop  in  1  single-cycle debounced pulse, toggle run/stop
- btn_clear  in  1  single-cycle pulse, clear
- btn_lap  in  1  single-cycle pulse, capture lap
- uart_rx  in  8  received byte
- uart_rx_done  in  1  single-cycle strobe, uart_rx valid
- mode  in  1  0 = count up, 1 = count down
- load  in  1  pulse, load preset (countdown)
- preset  in  24  {hour[4:0], min[5:0], sec[5:0], msec[6:0]}
- lap_rd  in  1  pop one lap entry
- msec  out  7  0..99
- sec  out  6  0..59
- min  out  6  0..59
- hour  out  5  0..HOUR_MAX-1
- running  out  1  FSM in RUN
- expired  out  1  one-cycle pulse, countdown reached zero
- lap_data  out  24  FIFO head, same packing as preset
- lap_valid  out  1  FIFO non-empty
- lap_count  out  $clog2(LAP_DEPTH)+1  entries held
- lap_ovf  out  1  sticky, lap dropped on full

Behaviour:
- Reset (rst=0, async): all time fields 0, FSM STOP, prescaler 0, FIFO empty, lap_count 0, lap_valid 0, lap_ovf 0, expired 0, mode latch 0.
- Command decode: events are the OR of button pulse and UART strobe with a matching byte. 'R'/'r' = runstop, 'C'/'c' = clear, 'L'/'l' = lap. Other bytes are ignored. Button and UART for the same command in the same cycle produce one event.
- FSM states: STOP, RUN.
  - STOP + runstop → RUN, unless the latched mode is down and the count is all-zero (stays STOP).
  - RUN + runstop → STOP.
  - STOP + clear → zero the time fields and prescaler, empty the FIFO, clear lap_ovf; stay STOP.
  - Clear in RUN is ignored.
  - runstop and clear in the same cycle in STOP: clear wins, stay STOP.
- Mode latch: `mode` is sampled into the latch every cycle in STOP. It is frozen during RUN.
- Load: `load` in STOP writes preset into the time fields and clears the prescaler. Out-of-range fields saturate to their max (99 / 59 / 59 / HOUR_MAX-1). Load in RUN is ignored. load and clear together: clear wins.
- Prescaler: counts 0..CLK_FREQ/TICK_HZ-1 while in RUN and holds in STOP. Tick is asserted at the terminal count; the time fields update on the next edge.
- Up count:
  - msec 99→0 carries into sec; sec 59→0 carries into min; min 59→0 carries into hour.
  - hour HOUR_MAX-1 with all lower fields at max wraps every field to 0 and keeps running.
- Down count:
  - Borrow chain is the mirror image of up count.
  - On the tick that makes all fields 0, FSM → STOP and expired=1 for exactly the following cycle.
  - No wrap below zero.
- Lap capture:
  - Accepted in RUN only; lap in STOP is ignored.
  - The entry is the current registered field values (pre-tick if a tick coincides). It is visible at the FIFO head / in lap_count on the next cycle.
  - FIFO full: new lap dropped, lap_ovf=1 until clear or reset.
- Lap read: lap_rd while lap_valid pops the head next cycle. lap_rd on empty is ignored.
- Simultaneous lap capture and lap_rd: both occur; count unchanged. When full, the push is still accepted because a pop occurs.
- Asynchronous reset mid-run returns every output to its reset value immediately.

Optional Feature:
- STOPWATCH_UART_CMD_EN: when defined, UART byte decode is active as above.
- When undefined, uart_rx / uart_rx_done are ignored (ports retained, no logic) and only buttons drive commands.

Test Plan:
- CLK_FREQ=1000, TICK_HZ=100, rst low then high, btn_runstop pulse, run 1000 cycles → msec=100? no: sec=1, msec=0, running=1. Then btn_runstop → running=0 and values hold for 50 cycles.
- Up-count rollover: load in STOP preset {1,59,59,99}, mode=0, HOUR_MAX=2, run one tick (10 cycles) → all fields 0, running stays 1.
- Countdown: mode=1, load {0,0,0,3}, runstop, 30 cycles → fields 0, expired high one cycle, running=0. A further runstop keeps running=0.
- Laps: LAP_DEPTH=4, run, five btn_lap pulses 10 cycles apart → lap_count=4, lap_ovf=1. Four lap_rd pops return increasing values, then lap_valid=0. btn_clear in STOP → lap_ovf=0.
- With STOPWATCH_UART_CMD_EN: uart_rx='r' + done → RUN. 'x' → no change. Same-cycle btn_runstop and 'R' → single toggle. Without the macro, 'r' → no change.
- Same-cycle btn_clear + btn_runstop in STOP at sec=5 → fields 0, running=0. rst asserted mid-RUN → all outputs reset asynchronously.
